ct_sysio_clint_src: RTL and testbench
=====================================

# ct_sysio_clint_src

Per-core CLINT interrupt source on the SoC side of the sysio boundary. It holds a 64-bit machine timer, machine/supervisor timer compare registers and software-interrupt pending bits. It drives the four level-sensitive lines `clint_core_ms_int`, `clint_core_mt_int`, `clint_core_ss_int` and `clint_core_st_int`, which the core's sysio sampler captures on `apb_clk_en`. Registers are accessed through a single-beat select/acknowledge register port in the APB clock-enable domain.

## Interface
- No parameters.
- `sysio_clk` in 1: block clock; all flops on its rising edge.
- `sysio_rst` in 1: asynchronous, active-high reset.
- `apb_clk_en` in 1: APB-domain clock enable; qualifies register-port acceptance.
- `time_tick` in 1: timebase tick; `mtime` increments on each `sysio_clk` cycle where it is high.
- `bus_sel` in 1: access request; held until `bus_ack`.
- `bus_wr` in 1: 1 = write, 0 = read; stable while `bus_sel` is high.
- `bus_addr` in 5: byte address; bits [4:2] select the register, bits [1:0] are ignored.
- `bus_wdata` in 32: write data.
- `bus_rdata` out 32: read data, valid only while `bus_ack` is high, 0 otherwise.
- `bus_ack` out 1: single-cycle response pulse.
- `clint_core_ms_int` out 1: machine software interrupt.
- `clint_core_mt_int` out 1: machine timer interrupt.
- `clint_core_ss_int` out 1: supervisor software interrupt.
- `clint_core_st_int` out 1: supervisor timer interrupt.

## Operation
- Register map, `bus_addr[4:2]`:
  - 0 `msip`: bit 0 only; other bits read 0.
  - 1 `ssip`: bit 0 only; other bits read 0.
  - 2 `mtimecmp[31:0]`, 3 `mtimecmp[63:32]`.
  - 4 `stimecmp[31:0]`, 5 `stimecmp[63:32]`.
  - 6 `mtime[31:0]`, 7 `mtime[63:32]`.
- Reset values:
  - `msip` = 0, `ssip` = 0, `mtime` = 0.
  - `mtimecmp` and `stimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - All outputs = 0.
- Port FSM has two states, IDLE and RESP.
  - IDLE -> RESP when `bus_sel && apb_clk_en`. The write is committed or the read data captured on this edge.
  - RESP: `bus_ack` = 1 for exactly one cycle, then -> IDLE unconditionally.
  - No new request is accepted in RESP. The master must deassert `bus_sel` in the cycle after `bus_ack`.
- `mtime` is a 64-bit up-counter with modulo wrap: FFFF_FFFF_FFFF_FFFF + tick -> 0.
  - A write to a `mtime` half in the same cycle as `time_tick` wins: the written half takes `bus_wdata`, the other half holds, and there is no increment that cycle.
- A write to one 32-bit half of any 64-bit register leaves the other half unchanged.
- A read of `mtime` returns the pre-increment value of the acceptance cycle.

## Timing
- Register access latency: accept edge, then `bus_ack`/`bus_rdata` in the next cycle. Minimum 2 cycles per access.
- `clint_core_mt_int` is registered as (`mtime` >= `mtimecmp`), unsigned 64-bit. It reflects register state one cycle after any change (tick or write).
- `clint_core_st_int` is the same against `stimecmp`.
- `clint_core_ms_int` and `clint_core_ss_int` are direct flop outputs of `msip[0]` and `ssip[0]`. They change on the write-accept edge, i.e. they are visible in the `bus_ack` cycle.
- Timer interrupts are level outputs, cleared only by raising the compare value or lowering `mtime`.
- Reset asserted mid-access: FSM -> IDLE, no ack, all registers and outputs return to reset values asynchronously.
- `apb_clk_en` low with `bus_sel` high: request waits; nothing changes.

## Configuration
- `SYSIO_CLINT_SMODE_EN` defined: `ssip` and `stimecmp` are implemented; `clint_core_ss_int` and `clint_core_st_int` are live.
- `SYSIO_CLINT_SMODE_EN` undefined:
  - `ssip` and `stimecmp` flops are removed.
  - Addresses 1, 4 and 5 read 0, and writes to them are acked and ignored.
  - `clint_core_ss_int` and `clint_core_st_int` are tied to 0.

## Test plan
- Reset: release `sysio_rst` -> all four interrupts 0, read addr 0x18 returns 0, read addr 0x0C returns 32'hFFFF_FFFF, each `bus_ack` exactly 1 cycle after accept.
- Timer fire: write `mtimecmp` lo=5, hi=0, then hold `time_tick`=1 -> `clint_core_mt_int` rises the cycle after `mtime` reaches 5 and stays high. Write hi=1 -> it falls one cycle later.
- Software interrupt: write 0x0000_0003 to addr 0x00 -> `clint_core_ms_int`=1 in the ack cycle, readback 0x1. Write 0 -> it drops.
- Wrap and collision: write `mtime` lo=FFFF_FFFF, hi=FFFF_FFFF, then tick -> `mtime` reads 0. Write lo=0x10 with `time_tick`=1 in the accept cycle -> lo reads 0x10, not 0x11.
- Handshake: hold `bus_sel` with `apb_clk_en`=0 for 4 cycles -> no ack. Raise `apb_clk_en` -> exactly one ack. Two back-to-back requests -> second accepted no earlier than 2 cycles after the first.
- S-mode: with `SYSIO_CLINT_SMODE_EN`, `stimecmp`=0 -> `clint_core_st_int`=1 one cycle later. Without it, the same write leaves `clint_core_st_int`=0 and addr 0x10 reads 0.

Source files
------------

// File: rtl/ct_sysio_clint_src_if.sv
// rtl/ct_sysio_clint_src_if.sv - select/acknowledge register port bundle for the CLINT source
interface ct_sysio_clint_src_if;
    logic        bus_sel;
    logic        bus_wr;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_sel,
        output bus_wr,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_sel,
        input  bus_wr,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/ct_sysio_clint_src.sv
// rtl/ct_sysio_clint_src.sv - per-core CLINT timer/software interrupt source
// Optional supervisor-mode sources enabled by SYSIO_CLINT_SMODE_EN.
module ct_sysio_clint_src (
    input  logic                        sysio_clk,
    input  logic                        sysio_rst,
    input  logic                        apb_clk_en,
    input  logic                        time_tick,
    ct_sysio_clint_src_if.slave         bus,
    output logic                        clint_core_ms_int,
    output logic                        clint_core_mt_int,
    output logic                        clint_core_ss_int,
    output logic                        clint_core_st_int
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        wr_en;
    logic [2:0]  reg_sel;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic        mt_int_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_mux;

    assign reg_sel = bus.bus_addr[4:2];
    assign wr_en   = accept && bus.bus_wr;

    always_ff @(posedge sysio_clk or posedge sysio_rst) begin
        if (sysio_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        bus.bus_ack = 1'b0;
        case (state)
            IDLE: begin
                if (bus.bus_sel && apb_clk_en) begin
                    accept    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                bus.bus_ack = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.bus_rdata = (state == RESP) ? rdata_q : 32'h0;

    always_ff @(posedge sysio_clk or posedge sysio_rst) begin
        if (sysio_rst) begin
            msip     <= 1'b0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (wr_en) begin
            case (reg_sel)
                3'd0:    msip            <= bus.bus_wdata[0];
                3'd2:    mtimecmp[31:0]  <= bus.bus_wdata;
                3'd3:    mtimecmp[63:32] <= bus.bus_wdata;
                default: ;
            endcase
        end
    end

    // A register write to either mtime half suppresses that cycle's tick.
    always_ff @(posedge sysio_clk or posedge sysio_rst) begin
        if (sysio_rst) begin
            mtime <= 64'h0;
        end else if (wr_en && (reg_sel == 3'd6)) begin
            mtime[31:0] <= bus.bus_wdata;
        end else if (wr_en && (reg_sel == 3'd7)) begin
            mtime[63:32] <= bus.bus_wdata;
        end else if (time_tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge sysio_clk or posedge sysio_rst) begin
        if (sysio_rst) begin
            mt_int_q <= 1'b0;
        end else begin
            mt_int_q <= (mtime >= mtimecmp);
        end
    end

`ifdef SYSIO_CLINT_SMODE_EN
    logic        ssip;
    logic [63:0] stimecmp;
    logic        st_int_q;

    always_ff @(posedge sysio_clk or posedge sysio_rst) begin
        if (sysio_rst) begin
            ssip     <= 1'b0;
            stimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (wr_en) begin
            case (reg_sel)
                3'd1:    ssip            <= bus.bus_wdata[0];
                3'd4:    stimecmp[31:0]  <= bus.bus_wdata;
                3'd5:    stimecmp[63:32] <= bus.bus_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sysio_clk or posedge sysio_rst) begin
        if (sysio_rst) begin
            st_int_q <= 1'b0;
        end else begin
            st_int_q <= (mtime >= stimecmp);
        end
    end

    assign clint_core_ss_int = ssip;
    assign clint_core_st_int = st_int_q;
`else
    assign clint_core_ss_int = 1'b0;
    assign clint_core_st_int = 1'b0;
`endif

    always_comb begin
        rdata_mux = 32'h0;
        case (reg_sel)
            3'd0: rdata_mux = {31'h0, msip};
`ifdef SYSIO_CLINT_SMODE_EN
            3'd1: rdata_mux = {31'h0, ssip};
            3'd4: rdata_mux = stimecmp[31:0];
            3'd5: rdata_mux = stimecmp[63:32];
`endif
            3'd2: rdata_mux = mtimecmp[31:0];
            3'd3: rdata_mux = mtimecmp[63:32];
            3'd6: rdata_mux = mtime[31:0];
            3'd7: rdata_mux = mtime[63:32];
            default: rdata_mux = 32'h0;
        endcase
    end

    // Captured on every accept so an mtime read returns the pre-tick value.
    always_ff @(posedge sysio_clk or posedge sysio_rst) begin
        if (sysio_rst) begin
            rdata_q <= 32'h0;
        end else if (accept) begin
            rdata_q <= rdata_mux;
        end
    end

    assign clint_core_ms_int = msip;
    assign clint_core_mt_int = mt_int_q;

endmodule

// File: tb/tb_ct_sysio_clint_src.sv
// tb/tb_ct_sysio_clint_src.sv - directed and randomized bench for ct_sysio_clint_src
module tb_ct_sysio_clint_src;

`ifdef SYSIO_CLINT_SMODE_EN
    localparam bit SMODE = 1'b1;
`else
    localparam bit SMODE = 1'b0;
`endif

    logic sysio_clk = 1'b0;
    logic sysio_rst = 1'b1;
    logic apb_clk_en = 1'b0;
    logic time_tick = 1'b0;
    logic clint_core_ms_int;
    logic clint_core_mt_int;
    logic clint_core_ss_int;
    logic clint_core_st_int;

    ct_sysio_clint_src_if bus_if ();

    ct_sysio_clint_src dut (
        .sysio_clk         (sysio_clk),
        .sysio_rst         (sysio_rst),
        .apb_clk_en        (apb_clk_en),
        .time_tick         (time_tick),
        .bus               (bus_if),
        .clint_core_ms_int (clint_core_ms_int),
        .clint_core_mt_int (clint_core_mt_int),
        .clint_core_ss_int (clint_core_ss_int),
        .clint_core_st_int (clint_core_st_int)
    );

    always #5 sysio_clk = ~sysio_clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_mtime;
    logic [63:0] m_mcmp;
    logic [63:0] m_scmp;
    logic        m_msip;
    logic        m_ssip;
    logic        m_busy;
    logic        m_was_read;
    logic [31:0] m_rdata;
    logic        e_mt;
    logic        e_st;
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mtime = 64'd0;
        m_mcmp  = '1;
        m_scmp  = '1;
        m_msip  = 1'b0;
        m_ssip  = 1'b0;
        m_busy  = 1'b0;
        e_mt    = 1'b0;
        e_st    = 1'b0;
        m_was_read = 1'b0;
        m_rdata = 32'd0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] r);
        case (r)
            3'd0: return {31'd0, m_msip};
            3'd1: return SMODE ? {31'd0, m_ssip} : 32'd0;
            3'd2: return m_mcmp[31:0];
            3'd3: return m_mcmp[63:32];
            3'd4: return SMODE ? m_scmp[31:0] : 32'd0;
            3'd5: return SMODE ? m_scmp[63:32] : 32'd0;
            3'd6: return m_mtime[31:0];
            default: return m_mtime[63:32];
        endcase
    endfunction

    // One clock: advance the reference model from the current inputs, then check.
    task automatic step();
        logic acc;
        logic wrote_time;
        logic [2:0] r;
        r = bus_if.bus_addr[4:2];
        e_mt = (m_mtime >= m_mcmp);
        e_st = SMODE && (m_scmp <= m_mtime);
        acc = !m_busy && bus_if.bus_sel && apb_clk_en;
        wrote_time = 1'b0;
        m_was_read = acc && !bus_if.bus_wr;
        if (m_was_read) m_rdata = model_read(r);
        if (acc && bus_if.bus_wr) begin
            case (r)
                3'd0: m_msip = bus_if.bus_wdata[0];
                3'd1: if (SMODE) m_ssip = bus_if.bus_wdata[0];
                3'd2: m_mcmp[31:0] = bus_if.bus_wdata;
                3'd3: m_mcmp[63:32] = bus_if.bus_wdata;
                3'd4: if (SMODE) m_scmp[31:0] = bus_if.bus_wdata;
                3'd5: if (SMODE) m_scmp[63:32] = bus_if.bus_wdata;
                3'd6: begin m_mtime[31:0] = bus_if.bus_wdata; wrote_time = 1'b1; end
                default: begin m_mtime[63:32] = bus_if.bus_wdata; wrote_time = 1'b1; end
            endcase
        end
        if (time_tick && !wrote_time) m_mtime = m_mtime + 64'd1;
        m_busy = acc;
        @(posedge sysio_clk);
        #1;
        chk("ack", 32'(bus_if.bus_ack), 32'(acc));
        if (acc && m_was_read) begin
            chk("rdata", bus_if.bus_rdata, m_rdata);
            last_rdata = bus_if.bus_rdata;
        end
        if (!acc) chk("rdata_idle", bus_if.bus_rdata, 32'd0);
        chk("mt_int", 32'(clint_core_mt_int), 32'(e_mt));
        chk("st_int", 32'(clint_core_st_int), 32'(e_st));
        chk("ms_int", 32'(clint_core_ms_int), 32'(m_msip));
        chk("ss_int", 32'(clint_core_ss_int), 32'(SMODE && m_ssip));
    endtask

    task automatic bus_op(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                          input logic tick);
        bus_if.bus_sel   = 1'b1;
        bus_if.bus_wr    = wr;
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = wdata;
        apb_clk_en = 1'b1;
        time_tick  = tick;
        step();
        bus_if.bus_sel = 1'b0;
        time_tick = 1'b0;
        step();
    endtask

    function automatic logic [31:0] rand_data(input logic [2:0] r);
        logic [31:0] d;
        d = $urandom;
        if (r[0] && r != 3'd1) begin
            case ($urandom_range(0, 3))
                0: d = 32'd0;
                1: d = 32'd1;
                2: d = 32'hFFFF_FFFF;
                default: ;
            endcase
        end
        return d;
    endfunction

    initial begin
        bus_if.bus_sel   = 1'b0;
        bus_if.bus_wr    = 1'b0;
        bus_if.bus_addr  = 5'd0;
        bus_if.bus_wdata = 32'd0;
        last_rdata = 32'd0;
        model_reset();
        #3;
        chk("rst_ack", 32'(bus_if.bus_ack), 32'd0);
        chk("rst_ints", {28'd0, clint_core_ms_int, clint_core_mt_int,
                         clint_core_ss_int, clint_core_st_int}, 32'd0);
        #9 sysio_rst = 1'b0;

        bus_op(1'b0, 5'h18, 32'd0, 1'b0);
        chk("reset_mtime_lo", last_rdata, 32'd0);
        bus_op(1'b0, 5'h0C, 32'd0, 1'b0);
        chk("reset_mtimecmp_hi", last_rdata, 32'hFFFF_FFFF);

        // timer fire and clear by raising the compare value
        bus_op(1'b1, 5'h08, 32'd5, 1'b0);
        bus_op(1'b1, 5'h0C, 32'd0, 1'b0);
        time_tick = 1'b1;
        for (int i = 0; i < 8; i++) step();
        time_tick = 1'b0;
        chk("mt_fired", 32'(clint_core_mt_int), 32'd1);
        bus_op(1'b1, 5'h0C, 32'd1, 1'b0);
        chk("mt_cleared", 32'(clint_core_mt_int), 32'd0);

        // software interrupt
        bus_op(1'b1, 5'h00, 32'h0000_0003, 1'b0);
        bus_op(1'b0, 5'h00, 32'd0, 1'b0);
        chk("msip_readback", last_rdata, 32'd1);
        bus_op(1'b1, 5'h00, 32'd0, 1'b0);
        chk("ms_dropped", 32'(clint_core_ms_int), 32'd0);

        // wrap and write/tick collision
        bus_op(1'b1, 5'h18, 32'hFFFF_FFFF, 1'b0);
        bus_op(1'b1, 5'h1C, 32'hFFFF_FFFF, 1'b0);
        time_tick = 1'b1;
        step();
        time_tick = 1'b0;
        bus_op(1'b0, 5'h18, 32'd0, 1'b0);
        chk("wrap_lo", last_rdata, 32'd0);
        bus_op(1'b0, 5'h1C, 32'd0, 1'b0);
        chk("wrap_hi", last_rdata, 32'd0);
        bus_op(1'b1, 5'h18, 32'h10, 1'b1);
        bus_op(1'b0, 5'h18, 32'd0, 1'b0);
        chk("collision_lo", last_rdata, 32'h10);

        // handshake stall and back-to-back
        bus_if.bus_sel  = 1'b1;
        bus_if.bus_wr   = 1'b0;
        bus_if.bus_addr = 5'h08;
        apb_clk_en = 1'b0;
        for (int i = 0; i < 4; i++) step();
        apb_clk_en = 1'b1;
        step();
        step();
        step();
        chk("b2b_second_ack", 32'(bus_if.bus_ack), 32'd1);
        bus_if.bus_sel = 1'b0;
        step();

        // supervisor sources
        bus_op(1'b1, 5'h04, 32'd1, 1'b0);
        chk("ss_int", 32'(clint_core_ss_int), 32'(SMODE));
        bus_op(1'b1, 5'h10, 32'd0, 1'b0);
        bus_op(1'b0, 5'h14, 32'd0, 1'b0);
        chk("stimecmp_hi", last_rdata, SMODE ? 32'hFFFF_FFFF : 32'd0);
        bus_op(1'b1, 5'h14, 32'd0, 1'b0);
        chk("st_int", 32'(clint_core_st_int), 32'(SMODE));
        bus_op(1'b0, 5'h10, 32'd0, 1'b0);
        chk("stimecmp_lo", last_rdata, 32'd0);

        // reset in the middle of an access
        bus_if.bus_sel   = 1'b1;
        bus_if.bus_wr    = 1'b1;
        bus_if.bus_addr  = 5'h00;
        bus_if.bus_wdata = 32'd1;
        apb_clk_en = 1'b1;
        step();
        sysio_rst = 1'b1;
        #1;
        chk("midrst_ack", 32'(bus_if.bus_ack), 32'd0);
        chk("midrst_ints", {28'd0, clint_core_ms_int, clint_core_mt_int,
                            clint_core_ss_int, clint_core_st_int}, 32'd0);
        bus_if.bus_sel = 1'b0;
        model_reset();
        #2 sysio_rst = 1'b0;
        bus_op(1'b0, 5'h08, 32'd0, 1'b0);
        chk("midrst_mtimecmp_lo", last_rdata, 32'hFFFF_FFFF);

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                apb_clk_en = 1'($urandom);
                time_tick  = 1'($urandom);
                step();
            end else begin
                int budget;
                logic [2:0] r;
                r = 3'($urandom_range(0, 7));
                bus_if.bus_sel   = 1'b1;
                bus_if.bus_wr    = 1'($urandom);
                bus_if.bus_addr  = {r, 2'($urandom)};
                bus_if.bus_wdata = rand_data(r);
                budget = 0;
                do begin
                    apb_clk_en = ($urandom_range(0, 3) != 0);
                    time_tick  = 1'($urandom);
                    step();
                    budget++;
                end while (!m_busy && budget < 50);
                if (!m_busy) chk("accept_timeout", 32'd0, 32'd1);
                bus_if.bus_sel = 1'b0;
                time_tick = 1'($urandom);
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
